// File: rtl/yrv_uart_pkg.sv
// rtl/yrv_uart_pkg.sv - shared types and constants for the yrv_m1 UART transmitter
// Purpose: FSM state encoding, data width and default bit period used by
//          yrv_uart_tx, yrv_uart_tx_if and yrv_uart_tx_fifo.
// Ports:   none (package)
package yrv_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int UART_DATA_W       = 8;
  localparam int UART_DEF_BIT_CLKS = 80;

endpackage

// File: rtl/yrv_uart_tx_if.sv
// rtl/yrv_uart_tx_if.sv - CPU-side write/status bundle of the UART transmitter
// Purpose: groups the data-register write strobe and the transmitter status.
// Signals: wr_en, wr_data[7:0], clr_ovr   (CPU -> transmitter)
//          tx_full, tx_empty, tx_busy, ovr_flag (transmitter -> CPU)
// Modports: master = CPU side, slave = transmitter side
interface yrv_uart_tx_if;
  import yrv_uart_pkg::*;

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   clr_ovr;
  logic                   tx_full;
  logic                   tx_empty;
  logic                   tx_busy;
  logic                   ovr_flag;

  modport master (
    output wr_en, wr_data, clr_ovr,
    input  tx_full, tx_empty, tx_busy, ovr_flag
  );

  modport slave (
    input  wr_en, wr_data, clr_ovr,
    output tx_full, tx_empty, tx_busy, ovr_flag
  );

endinterface

// File: rtl/yrv_uart_tx_fifo.sv
// rtl/yrv_uart_tx_fifo.sv - DEPTH x W synchronous FIFO feeding the UART transmitter
// Purpose: buffers bytes written by the CPU until the serialiser takes them.
// Ports:   clk, resetn (async, active-low)
//          push, wdata[W-1:0] : enqueue (ignored when full)
//          pop                : dequeue (ignored when empty)
//          head[W-1:0]        : oldest entry
//          full, empty        : derived from the pointer flops
module yrv_uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full (MSBs differ) from empty (equal).
  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic         do_push;
  logic         do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/yrv_uart_tx.sv
// rtl/yrv_uart_tx.sv - yrv_m1 UART serial transmitter (8N1, optional 8E1)
// Purpose: takes bytes from the CPU data register through a small FIFO and
//          serialises them on ser_txd: start, 8 data bits LSB first, stop.
// Ports:   clk     : cpu clock, all state on posedge
//          resetn  : asynchronous active-low reset
//          bus     : yrv_uart_tx_if.slave (wr_en, wr_data, clr_ovr,
//                    tx_full, tx_empty, tx_busy, ovr_flag)
//          ser_txd : serial line, idle high, driven from a flop
// Params:  BIT_CLKS (clk per bit, >= 2), FIFO_DEPTH (power of 2, >= 2)
// Config:  YRV_UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module yrv_uart_tx
  import yrv_uart_pkg::*;
#(
  parameter int BIT_CLKS   = UART_DEF_BIT_CLKS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetn,
  yrv_uart_tx_if.slave  bus,
  output logic          ser_txd
);

  localparam int             CW      = $clog2(BIT_CLKS);
  localparam logic [CW-1:0]  CNT_MAX = CW'(BIT_CLKS - 1);

  tx_state_t              state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   txd_q, txd_d;
  logic                   ovr_q;
  logic                   bit_end;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [UART_DATA_W-1:0] fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;

`ifdef YRV_UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  // Writes are gated by the registered full flag, so a pop in the same
  // cycle does not rescue a write that arrives while full.
  assign fifo_push = bus.wr_en & ~fifo_full;

  yrv_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .wdata  (bus.wr_data),
    .pop    (fifo_pop),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bit_end      = (bit_cnt_q == CNT_MAX);
  assign ser_txd      = txd_q;
  assign bus.tx_full  = fifo_full;
  assign bus.tx_busy  = (state_q != IDLE);
  assign bus.tx_empty = fifo_empty & (state_q == IDLE);
  assign bus.ovr_flag = ovr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      ovr_q     <= 1'b0;
`ifdef YRV_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
`ifdef YRV_UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
      // A dropped write wins over a simultaneous clear.
      if (bus.wr_en && fifo_full) ovr_q <= 1'b1;
      else if (bus.clr_ovr)       ovr_q <= 1'b0;
    end
  end

  // txd_d is the line value for the cycle after the edge, so every state
  // change loads the first value of the next slot at the same time.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;
`ifdef YRV_UART_TX_PARITY_EN
    par_d     = par_q;
`endif

    if (state_q != IDLE) begin
      bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_head;
`ifdef YRV_UART_TX_PARITY_EN
          par_d     = ^fifo_head;
`endif
          bit_cnt_d = '0;
          txd_d     = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          txd_d     = shift_q[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
`ifdef YRV_UART_TX_PARITY_EN
            txd_d   = par_q;
            state_d = PARITY;
`else
            txd_d   = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
      end
`ifdef YRV_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // Back-to-back frame: no idle cycle between stop and start.
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
`ifdef YRV_UART_TX_PARITY_EN
            par_d    = ^fifo_head;
`endif
            txd_d    = 1'b0;
            state_d  = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        txd_d     = 1'b1;
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

endmodule
